// File: rtl/bus_cycle_seq_pkg.sv
// Shared encodings for bus machine cycles and T-states, used by the
// instruction sequencer, the bus cycle sequencer and its bench.
package bus_cycle_seq_pkg;

   typedef enum logic [2:0] {
      CYC_M1   = 3'd0,
      CYC_MRD  = 3'd1,
      CYC_MWR  = 3'd2,
      CYC_IORD = 3'd3,
      CYC_IOWR = 3'd4
   } cyc_type_e;

   typedef enum logic [2:0] {
      TS_IDLE = 3'd0,
      TS_T1   = 3'd1,
      TS_T2   = 3'd2,
      TS_TW   = 3'd3,
      TS_T3   = 3'd4,
      TS_T4   = 3'd5
   } t_state_e;

   localparam int WCNT_W = 2;

   function automatic logic cyc_is_valid(input logic [2:0] t);
      return t <= 3'd4;
   endfunction

   function automatic logic cyc_is_io(input cyc_type_e t);
      return (t == CYC_IORD) || (t == CYC_IOWR);
   endfunction

endpackage

// File: rtl/bus_pin_decode.sv
// Combinational map from {T-state, latched cycle type} to the bus control
// pins, data-latch enables and busy/done status.
module bus_pin_decode
   import bus_cycle_seq_pkg::*;
(
   input  logic [2:0] state,
   input  logic [2:0] cyc,
   output logic       busy,
   output logic       done,
   output logic       n_m1,
   output logic       n_mreq,
   output logic       n_iorq,
   output logic       n_rd,
   output logic       n_wr,
   output logic       n_rfsh,
   output logic       db_oe,
   output logic       db_re
);

   t_state_e  st;
   cyc_type_e ct;

   assign st = t_state_e'(state);
   assign ct = cyc_type_e'(cyc);

   always_comb begin
      busy   = (st != TS_IDLE);
      done   = 1'b0;
      n_m1   = 1'b1;
      n_mreq = 1'b1;
      n_iorq = 1'b1;
      n_rd   = 1'b1;
      n_wr   = 1'b1;
      n_rfsh = 1'b1;
      db_oe  = 1'b0;
      db_re  = 1'b0;
      case (ct)
         CYC_M1: begin
            case (st)
               TS_T1, TS_T2, TS_TW: begin
                  n_m1   = 1'b0;
                  n_mreq = 1'b0;
                  n_rd   = 1'b0;
               end
               TS_T3: begin
                  n_mreq = 1'b0;
                  n_rfsh = 1'b0;
                  db_re  = 1'b1;
               end
               TS_T4: begin
                  n_rfsh = 1'b0;
                  done   = 1'b1;
               end
               default: ;
            endcase
         end
         CYC_MRD: begin
            if (st inside {TS_T1, TS_T2, TS_TW, TS_T3}) begin
               n_mreq = 1'b0;
               n_rd   = 1'b0;
            end
            if (st == TS_T3) begin
               db_re = 1'b1;
               done  = 1'b1;
            end
         end
         CYC_MWR: begin
            if (st inside {TS_T1, TS_T2, TS_TW, TS_T3}) begin
               n_mreq = 1'b0;
               db_oe  = 1'b1;
            end
            if (st inside {TS_T2, TS_TW, TS_T3})
               n_wr = 1'b0;
            if (st == TS_T3)
               done = 1'b1;
         end
         CYC_IORD, CYC_IOWR: begin
            // T1 carries address only; the I/O strobes start in T2.
            if (st inside {TS_T2, TS_TW, TS_T3}) begin
               n_iorq = 1'b0;
               if (ct == CYC_IORD) n_rd = 1'b0;
               else                n_wr = 1'b0;
            end
            if (ct == CYC_IOWR && st inside {TS_T1, TS_T2, TS_TW, TS_T3})
               db_oe = 1'b1;
            if (st == TS_T3) begin
               db_re = (ct == CYC_IORD);
               done  = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bus_cycle_seq.sv
// Machine-cycle T-state sequencer: expands one bus request into
// T1/T2/TW*/T3/(T4) and drives registered bus control pins.
//
// state   | meaning
// IDLE    | no bus cycle, all pins inactive
// T1      | address phase
// T2      | strobes start; nWAIT sampled here unless I/O auto-waits follow
// TW      | wait state (auto I/O wait while wcnt_q != 0, else nWAIT-driven)
// T3      | data transfer; last state except for opcode fetch
// T4      | opcode fetch refresh tail
module bus_cycle_seq
   import bus_cycle_seq_pkg::*;
#(
   parameter int IO_WAIT_STATES = 1,
   parameter int TSTATE_W       = 3
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic                cycle_start,
   input  logic [2:0]          cycle_type,
   input  logic                nWAIT,
   output logic                busy,
   output logic                done,
   output logic [TSTATE_W-1:0] t_state,
   output logic                nM1,
   output logic                nMREQ,
   output logic                nIORQ,
   output logic                nRD,
   output logic                nWR,
   output logic                nRFSH,
   output logic                bus_db_pin_oe,
   output logic                bus_db_pin_re
);

   t_state_e          state_q, state_d;
   cyc_type_e         type_q, type_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              accept, last_ts;

   logic busy_q, done_q, n_m1_q, n_mreq_q, n_iorq_q, n_rd_q, n_wr_q, n_rfsh_q, oe_q, re_q;
   logic busy_d, done_d, n_m1_d, n_mreq_d, n_iorq_d, n_rd_d, n_wr_d, n_rfsh_d, oe_d, re_d;

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      wcnt_d  = wcnt_q;
      accept  = cycle_start && cyc_is_valid(cycle_type);
      last_ts = (state_q == TS_T4) || (state_q == TS_T3 && type_q != CYC_M1);
      case (state_q)
         TS_T1: state_d = TS_T2;
         TS_T2: begin
            if (cyc_is_io(type_q) && IO_WAIT_STATES > 0) begin
               state_d = TS_TW;
               wcnt_d  = WCNT_W'(IO_WAIT_STATES - 1);
            end else begin
               state_d = nWAIT ? TS_T3 : TS_TW;
            end
         end
         TS_TW: begin
            if (wcnt_q != '0) wcnt_d  = wcnt_q - 1'b1;
            else              state_d = nWAIT ? TS_T3 : TS_TW;
         end
         TS_T3:   state_d = (type_q == CYC_M1) ? TS_T4 : TS_IDLE;
         default: state_d = TS_IDLE;
      endcase
      // Accepting in the done state chains cycles with no idle gap.
      if ((state_q == TS_IDLE || last_ts) && accept) begin
         state_d = TS_T1;
         type_d  = cyc_type_e'(cycle_type);
      end
   end

   // Decode the next state so the pins come out of flops aligned to it.
   bus_pin_decode u_decode (
      .state  (state_d),
      .cyc    (type_d),
      .busy   (busy_d),
      .done   (done_d),
      .n_m1   (n_m1_d),
      .n_mreq (n_mreq_d),
      .n_iorq (n_iorq_d),
      .n_rd   (n_rd_d),
      .n_wr   (n_wr_d),
      .n_rfsh (n_rfsh_d),
      .db_oe  (oe_d),
      .db_re  (re_d)
   );

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q  <= TS_IDLE;
         type_q   <= CYC_M1;
         wcnt_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         n_m1_q   <= 1'b1;
         n_mreq_q <= 1'b1;
         n_iorq_q <= 1'b1;
         n_rd_q   <= 1'b1;
         n_wr_q   <= 1'b1;
         n_rfsh_q <= 1'b1;
         oe_q     <= 1'b0;
         re_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         type_q   <= type_d;
         wcnt_q   <= wcnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         n_m1_q   <= n_m1_d;
         n_mreq_q <= n_mreq_d;
         n_iorq_q <= n_iorq_d;
         n_rd_q   <= n_rd_d;
         n_wr_q   <= n_wr_d;
         n_rfsh_q <= n_rfsh_d;
         oe_q     <= oe_d;
         re_q     <= re_d;
      end
   end

   assign t_state       = TSTATE_W'(state_q);
   assign busy          = busy_q;
   assign done          = done_q;
   assign nM1           = n_m1_q;
   assign nMREQ         = n_mreq_q;
   assign nIORQ         = n_iorq_q;
   assign nRD           = n_rd_q;
   assign nWR           = n_wr_q;
   assign nRFSH         = n_rfsh_q;
   assign bus_db_pin_oe = oe_q;
   assign bus_db_pin_re = re_q;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// Directed bench for bus_cycle_seq: per-clock expected {t_state, busy, done,
// pins, oe/re} vectors for each machine cycle type, WAIT, chaining and reset.
module tb_bus_cycle_seq;
   import bus_cycle_seq_pkg::*;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       cycle_start = 1'b0;
   logic [2:0] cycle_type = 3'd0;
   logic       nWAIT = 1'b1;
   logic       busy, done;
   logic [2:0] t_state;
   logic       nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
   logic       bus_db_pin_oe, bus_db_pin_re;

   int n_checks = 0;
   int n_fail   = 0;

   // pin order: nM1 nMREQ nIORQ nRD nWR nRFSH
   localparam logic [5:0] P_IDLE   = 6'b111111;
   localparam logic [5:0] P_M1_FET = 6'b001011;
   localparam logic [5:0] P_M1_T3  = 6'b101110;
   localparam logic [5:0] P_M1_T4  = 6'b111110;
   localparam logic [5:0] P_MRD    = 6'b101011;
   localparam logic [5:0] P_MWR_T1 = 6'b101111;
   localparam logic [5:0] P_MWR    = 6'b101101;
   localparam logic [5:0] P_IORD   = 6'b110011;
   localparam logic [5:0] P_IOWR   = 6'b110101;

   bus_cycle_seq #(.IO_WAIT_STATES(1), .TSTATE_W(3)) dut (
      .clk           (clk),
      .nreset        (nreset),
      .cycle_start   (cycle_start),
      .cycle_type    (cycle_type),
      .nWAIT         (nWAIT),
      .busy          (busy),
      .done          (done),
      .t_state       (t_state),
      .nM1           (nM1),
      .nMREQ         (nMREQ),
      .nIORQ         (nIORQ),
      .nRD           (nRD),
      .nWR           (nWR),
      .nRFSH         (nRFSH),
      .bus_db_pin_oe (bus_db_pin_oe),
      .bus_db_pin_re (bus_db_pin_re)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [12:0] act, input logic [12:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got ts/busy/done/pins/oere=%b expected %b", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input string tag, input logic [2:0] ts, input logic b, input logic d,
                            input logic [5:0] pins, input logic [1:0] oere);
      chk(tag, {t_state, busy, done, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, bus_db_pin_oe, bus_db_pin_re},
          {ts, b, d, pins, oere});
   endtask

   task automatic start(input logic [2:0] t);
      cycle_start = 1'b1;
      cycle_type  = t;
      tick();
      cycle_start = 1'b0;
      cycle_type  = 3'd7;
   endtask

   initial begin
      // 1: reset then idle
      nreset = 1'b0;
      tick();
      tick();
      expect_st("rst", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);
      nreset = 1'b1;
      tick();
      expect_st("idle0", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);
      tick();
      expect_st("idle1", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);

      // 2: opcode fetch, request while busy is ignored
      nWAIT = 1'b1;
      start(CYC_M1);
      expect_st("m1_t1", 3'd1, 1'b1, 1'b0, P_M1_FET, 2'b00);
      cycle_start = 1'b1;
      cycle_type  = CYC_MRD;
      tick();
      cycle_start = 1'b0;
      expect_st("m1_t2", 3'd2, 1'b1, 1'b0, P_M1_FET, 2'b00);
      tick();
      expect_st("m1_t3", 3'd4, 1'b1, 1'b0, P_M1_T3, 2'b01);
      tick();
      expect_st("m1_t4", 3'd5, 1'b1, 1'b1, P_M1_T4, 2'b00);
      tick();
      expect_st("m1_end", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);

      // 3: mem read with three wait samples low
      nWAIT = 1'b0;
      start(CYC_MRD);
      expect_st("mrd_t1", 3'd1, 1'b1, 1'b0, P_MRD, 2'b00);
      tick();
      expect_st("mrd_t2", 3'd2, 1'b1, 1'b0, P_MRD, 2'b00);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_st($sformatf("mrd_tw%0d", i), 3'd3, 1'b1, 1'b0, P_MRD, 2'b00);
      end
      nWAIT = 1'b1;
      tick();
      expect_st("mrd_t3", 3'd4, 1'b1, 1'b1, P_MRD, 2'b01);
      tick();
      expect_st("mrd_end", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);

      // 4: I/O write, one automatic TW even with nWAIT high
      start(CYC_IOWR);
      expect_st("iow_t1", 3'd1, 1'b1, 1'b0, P_IDLE, 2'b10);
      tick();
      expect_st("iow_t2", 3'd2, 1'b1, 1'b0, P_IOWR, 2'b10);
      tick();
      expect_st("iow_tw", 3'd3, 1'b1, 1'b0, P_IOWR, 2'b10);
      tick();
      expect_st("iow_t3", 3'd4, 1'b1, 1'b1, P_IOWR, 2'b10);
      tick();
      expect_st("iow_end", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);

      // I/O read: auto TW, then one real wait sampled at its end
      start(CYC_IORD);
      expect_st("ior_t1", 3'd1, 1'b1, 1'b0, P_IDLE, 2'b00);
      tick();
      expect_st("ior_t2", 3'd2, 1'b1, 1'b0, P_IORD, 2'b00);
      tick();
      expect_st("ior_tw_auto", 3'd3, 1'b1, 1'b0, P_IORD, 2'b00);
      nWAIT = 1'b0;
      tick();
      expect_st("ior_tw_ext", 3'd3, 1'b1, 1'b0, P_IORD, 2'b00);
      nWAIT = 1'b1;
      tick();
      expect_st("ior_t3", 3'd4, 1'b1, 1'b1, P_IORD, 2'b01);
      tick();
      expect_st("ior_end", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);

      // 5: mem write chained into opcode fetch from the done cycle
      start(CYC_MWR);
      expect_st("mwr_t1", 3'd1, 1'b1, 1'b0, P_MWR_T1, 2'b10);
      tick();
      expect_st("mwr_t2", 3'd2, 1'b1, 1'b0, P_MWR, 2'b10);
      tick();
      expect_st("mwr_t3", 3'd4, 1'b1, 1'b1, P_MWR, 2'b10);
      start(CYC_M1);
      expect_st("chain_t1", 3'd1, 1'b1, 1'b0, P_M1_FET, 2'b00);
      tick();
      expect_st("chain_t2", 3'd2, 1'b1, 1'b0, P_M1_FET, 2'b00);
      tick();
      expect_st("chain_t3", 3'd4, 1'b1, 1'b0, P_M1_T3, 2'b01);
      tick();
      expect_st("chain_t4", 3'd5, 1'b1, 1'b1, P_M1_T4, 2'b00);
      tick();
      expect_st("chain_end", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);

      // 6: reset during TW aborts; invalid type stays idle
      nWAIT = 1'b0;
      start(CYC_MRD);
      tick();
      tick();
      expect_st("abort_tw", 3'd3, 1'b1, 1'b0, P_MRD, 2'b00);
      nreset = 1'b0;
      tick();
      nreset = 1'b1;
      nWAIT  = 1'b1;
      expect_st("abort_idle", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);
      start(3'd6);
      expect_st("bad_type0", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);
      tick();
      expect_st("bad_type1", 3'd0, 1'b0, 1'b0, P_IDLE, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_cycle_seq.md
Name: bus_cycle_seq

Overview:
Machine-cycle T-state sequencer that drives the CPU's external bus control pins (nM1, nMREQ, nIORQ, nRD, nWR, nRFSH). It also generates bus_db_pin_oe and bus_db_pin_re, the enables that control the data-pin latch directly downstream. The internal instruction sequencer issues one bus cycle at a time. This block expands each request into T1/T2/(TW…)/T3/(T4) timing, with WAIT insertion and automatic I/O wait states.

Parameters:
IO_WAIT_STATES, 1, number of automatic TW states inserted in I/O cycles after T2 (0–3).
TSTATE_W, 3, width of t_state output.

Ports:
clk  input  1  CPU clock; all logic on rising edge.
nreset  input  1  synchronous active-low reset.
cycle_start  input  1  one-clock request pulse, sampled only when busy=0 or done=1.
cycle_type  input  3  0=opcode fetch (M1), 1=mem read, 2=mem write, 3=io read, 4=io write, 5–7 invalid.
nWAIT  input  1  external wait, active low, already synchronised.
busy  output  1  high from T1 through the last T-state of the cycle.
done  output  1  one-clock pulse in the last T-state.
t_state  output  TSTATE_W  0=IDLE, 1=T1, 2=T2, 3=TW, 4=T3, 5=T4.
nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  output  1 each  bus control pins, active low, registered.
bus_db_pin_oe  output  1  drive internal data latch onto the D pins.
bus_db_pin_re  output  1  latch the D pins into the data latch.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on nreset. When nreset=0 at an edge, the next state is IDLE; all active-low pins go to 1; busy, done, bus_db_pin_oe and bus_db_pin_re go to 0; t_state goes to 0. Reset mid-cycle aborts the cycle at that edge with no done pulse.
- All outputs are decoded from the registered state and type, so each output is constant for a whole T-state.
- Acceptance: cycle_start with a valid type, seen in IDLE or in the done cycle, latches cycle_type. The next state is T1, so back-to-back cycles run with no idle gap.
  - cycle_start while busy=1 and done=0 is ignored.
  - An invalid type is ignored, and the block stays or returns to IDLE.
- Opcode fetch: T1, T2, TW* and T3 of the fetch phase, then T4.
  - T1, T2, TW: nM1=0, nMREQ=0, nRD=0.
  - T3: nM1=1, nRD=1, nMREQ=0, nRFSH=0, bus_db_pin_re=1.
  - T4: nMREQ=1, nRFSH=0, done=1.
- Mem read: T1 and T2 (plus TW) have nMREQ=0 and nRD=0. T3 has nMREQ=0, nRD=0, bus_db_pin_re=1 and done=1.
- Mem write:
  - bus_db_pin_oe=1 and nMREQ=0 throughout T1 to T3.
  - nWR=0 in T2, TW and T3 (not T1).
  - done in T3.
- I/O read/write:
  - T1: no strobes asserted.
  - T2 and each TW: nIORQ=0 with nRD=0 (read) or nWR=0 (write).
  - Write holds bus_db_pin_oe=1 from T1 to T3.
  - T3: read asserts bus_db_pin_re=1, and done=1.
- WAIT:
  - nWAIT is sampled at the end of T2 and of every TW, except I/O auto-wait TWs.
  - nWAIT=0 → next state TW. nWAIT=1 → next state T3.
  - In I/O cycles, the IO_WAIT_STATES automatic TWs always follow T2 first, and nWAIT is sampled only at the last one.
  - With IO_WAIT_STATES=0, I/O samples nWAIT at T2, the same as memory cycles.
  - Wait length is unbounded.
- bus_db_pin_re is asserted for exactly one clock per read cycle. bus_db_pin_oe and bus_db_pin_re are never both 1.
- After done, with no new accepted request, next state IDLE: all pins inactive.

Decomposition:
- Shared package: cycle_type encodings (CYC_M1, CYC_MRD, CYC_MWR, CYC_IORD, CYC_IOWR) and t_state encodings (TS_IDLE, TS_T1, TS_T2, TS_TW, TS_T3, TS_T4). The instruction sequencer and the testbench share these.
- One sub-module, bus_pin_decode: purely combinational map from {state, latched type} to the eight pin and enable values. The top level holds the state register, type latch, auto-wait counter and WAIT logic.

Test Plan:
1. Reset for 2 clocks, then release, no start → all n* pins=1, oe=re=0, t_state=0, busy=0 held.
2. M1 fetch, nWAIT=1 → t_state 1,2,4,5. nM1=0 for 2 clocks, re=1 only in T3, nRFSH=0 in T3–T4, done in clock 4.
3. Mem read with nWAIT=0 for 3 samples → T1, T2, TW, TW, TW, T3. nRD=0 for 5 clocks, then re=1 and done in T3.
4. I/O write with IO_WAIT_STATES=1 and nWAIT=1 → T1, T2, TW, T3. nIORQ=nWR=0 for 3 clocks, oe=1 for 4 clocks, done in clock 4.
5. Mem write back-to-back with M1 (cycle_start in the done cycle) → the next clock is T1 of M1, with busy continuously 1.
6. nreset=0 during TW of a mem read → next clock IDLE, no done pulse. cycle_start with type=6 afterwards → stays IDLE.
